conv_window_3x3_64x64: RTL and testbench

CONV_WINDOW_3X3_64X64 -- requirements
Module: conv_window_3x3_64x64

---
 rtl/conv_window_3x3_64x64.sv | 166 ++++++++++++++++
 tb/tb_conv_window_3x3_64x64.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_3x3_64x64.sv
// Dilated 3x3 sliding-window generator over a raster stream of square frames.
// Define CONV_WINDOW_ZERO_PAD_EN to emit every centre with out-of-frame taps forced to zero.
module conv_window_3x3_64x64 #(
   parameter int DATA_WIDTH      = 64,
   parameter int IMAGE_WIDTH     = 64,
   parameter int RATE            = 1,
   parameter int CHANNEL_NUM_IN  = 256,
   parameter int CHANNEL_NUM_OUT = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_in,
   input  logic [DATA_WIDTH-1:0]   pxl_in,
   output logic [9*DATA_WIDTH-1:0] win_out,
   output logic                    valid_out,
   output logic                    last_out,
   output logic [1:0]              state_o
);
   localparam int FRAME_NUM = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
   localparam int LAG       = RATE * IMAGE_WIDTH + RATE;
   localparam int TOTAL     = FRAME_NUM * IMAGE_WIDTH * IMAGE_WIDTH;
   localparam int PW        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int FW        = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
   localparam int CW        = $clog2(TOTAL + LAG + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] FLUSH = 2'd3;

   logic [1:0]              st_q, st_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [PW-1:0]           row_q, row_d, col_q, col_d;
   logic [FW-1:0]           frm_q, frm_d;
   logic                    push, emit;
   logic [DATA_WIDTH-1:0]   din;
   logic [9*DATA_WIDTH-1:0] win_d, win_q;
   logic                    valid_d, valid_q, last_d, last_q;

   // sr_d[0] is the incoming pixel, so the stored registers plus the head span 2*LAG+1 pixels
   logic [DATA_WIDTH-1:0]   sr_q [0:2*LAG-1];
   logic [DATA_WIDTH-1:0]   sr_d [0:2*LAG];

   // cnt_q counts layer pushes in FILL/RUN and zero pushes in FLUSH
   always_comb begin
      push  = 1'b0;
      din   = '0;
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
         IDLE: if (valid_in) begin
            push  = 1'b1;
            din   = pxl_in;
            cnt_d = CW'(1);
            st_d  = FILL;
         end
         FILL: if (valid_in) begin
            push  = 1'b1;
            din   = pxl_in;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LAG - 1)) st_d = RUN;
         end
         RUN: if (valid_in) begin
            push  = 1'b1;
            din   = pxl_in;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(TOTAL - 1)) begin
               st_d  = FLUSH;
               cnt_d = '0;
            end
         end
         default: begin
            push  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LAG - 1)) begin
               st_d  = IDLE;
               cnt_d = '0;
            end
         end
      endcase
      emit = push && ((st_q == RUN) || (st_q == FLUSH));
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      frm_d = frm_q;
      if (emit) begin
         if (col_q == PW'(IMAGE_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == PW'(IMAGE_WIDTH - 1)) begin
               row_d = '0;
               frm_d = (frm_q == FW'(FRAME_NUM - 1)) ? '0 : frm_q + FW'(1);
            end else begin
               row_d = row_q + PW'(1);
            end
         end else begin
            col_d = col_q + PW'(1);
         end
      end
   end

   always_comb begin
      sr_d[0] = din;
      for (int k = 1; k <= 2*LAG; k++) sr_d[k] = sr_q[k-1];
   end

   // Tap (i,j) sits (2-i) dilated rows and (2-j) dilated columns behind the newest pixel
   always_comb begin
      win_d = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            win_d[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = sr_d[(2-i)*RATE*IMAGE_WIDTH + (2-j)*RATE];
`ifdef CONV_WINDOW_ZERO_PAD_EN
            if ((int'(row_q) + (i-1)*RATE) < 0 || (int'(row_q) + (i-1)*RATE) >= IMAGE_WIDTH ||
                (int'(col_q) + (j-1)*RATE) < 0 || (int'(col_q) + (j-1)*RATE) >= IMAGE_WIDTH)
               win_d[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
         end
      end
   end

   always_comb begin
`ifdef CONV_WINDOW_ZERO_PAD_EN
      valid_d = emit;
`else
      valid_d = emit &&
                int'(row_q) >= RATE && int'(row_q) <= IMAGE_WIDTH - 1 - RATE &&
                int'(col_q) >= RATE && int'(col_q) <= IMAGE_WIDTH - 1 - RATE;
`endif
      last_d = emit && (row_q == PW'(IMAGE_WIDTH - 1)) && (col_q == PW'(IMAGE_WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int k = 0; k < 2*LAG; k++) sr_q[k] <= sr_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         frm_q   <= '0;
         win_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         col_q   <= col_d;
         frm_q   <= frm_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         if (emit) win_q <= win_d;
      end
   end

   assign win_out   = win_q;
   assign valid_out = valid_q;
   assign last_out  = last_q;
   assign state_o   = st_q;
endmodule

// File: tb/tb_conv_window_3x3_64x64.sv
// Bench for conv_window_3x3_64x64: frame-level window model, directed and random streams.
module tb_conv_window_3x3_64x64;
  localparam int DW    = 8;
  localparam int IW    = 4;
  localparam int RATE  = 1;
  localparam int FN    = 2;
  localparam int LAG   = RATE * IW + RATE;
  localparam int TOTAL = FN * IW * IW;
  localparam int EW    = 9 * DW + 2;
`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int TRIG_IDX = LAG;
  localparam logic [9*DW-1:0] FIRST_WIN =
    {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [9*DW-1:0] C33_WIN =
    {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd14, 8'd0, 8'd11, 8'd10};
`else
  localparam bit PAD = 1'b0;
  localparam int TRIG_IDX = 2 * LAG;
  localparam logic [9*DW-1:0] FIRST_WIN =
    {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_in;
  logic [DW-1:0]   pxl_in;
  logic [9*DW-1:0] win_out;
  logic            valid_out;
  logic            last_out;
  logic [1:0]      state_o;

  conv_window_3x3_64x64 #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .RATE(RATE),
    .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(1)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .win_out(win_out), .valid_out(valid_out), .last_out(last_out), .state_o(state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard state; entry = {valid, last, window}
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] stream [TOTAL];
  int n_vec = 0, n_err = 0;
  int n_exp, ev_cnt, run_id, trig_cyc, idle_cyc;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: every centre of every frame, taps looked up in the frame by coordinates
  task automatic build_model();
    exp_q.delete();
    n_exp = 0;
    for (int f = 0; f < FN; f++)
      for (int r = 0; r < IW; r++)
        for (int c = 0; c < IW; c++) begin
          logic [9*DW-1:0] w;
          bit inr, lst;
          w = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              int rr, cc;
              rr = r + (i - 1) * RATE;
              cc = c + (j - 1) * RATE;
              if (rr >= 0 && rr < IW && cc >= 0 && cc < IW)
                w[(3*i+j)*DW +: DW] = stream[f*IW*IW + rr*IW + cc];
            end
          inr = (r >= RATE) && (r <= IW-1-RATE) && (c >= RATE) && (c <= IW-1-RATE);
          lst = (r == IW-1) && (c == IW-1);
          if (PAD || inr) begin
            exp_q.push_back({1'b1, lst, w});
            n_exp++;
          end else if (lst) begin
            exp_q.push_back({1'b0, 1'b1, {9*DW{1'b0}}});
            n_exp++;
          end
        end
  endtask

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (valid_out || last_out) begin
        logic [EW-1:0] e;
        ev_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_event", EW'(ev_cnt), EW'(n_exp));
        end else begin
          e = exp_q.pop_front();
          check("valid_last", EW'({valid_out, last_out}), EW'(e[EW-1 -: 2]));
          if (e[EW-1]) check("window", EW'(win_out), EW'(e[9*DW-1:0]));
        end
        if (ev_cnt == 1) check("latency", EW'(cyc), EW'(trig_cyc));
        if (run_id == 1 && ev_cnt == 1) check("first_win", EW'(win_out), EW'(FIRST_WIN));
`ifdef CONV_WINDOW_ZERO_PAD_EN
        if (run_id == 1 && ev_cnt == IW*IW) begin
          check("c33_win", EW'(win_out), EW'(C33_WIN));
          check("c33_last", EW'(last_out), EW'(1));
        end
`endif
      end
      if (cyc == idle_cyc) check("gap_no_valid", EW'(valid_out), EW'(0));
    end
  end

  // driver tasks
  task automatic drive_stream(input int mode, input int n_px);
    bit gap;
    for (int p = 0; p < n_px; p++) begin
      valid_in = 1'b1;
      pxl_in   = stream[p];
      @(posedge clk); #1;
      if (p == TRIG_IDX) trig_cyc = cyc;
      gap = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      valid_in = 1'b0;
      pxl_in   = '0;
      if (gap && p < n_px - 1) begin
        @(posedge clk); #1;
        idle_cyc = cyc;
      end
    end
    if (mode == 2) begin
      valid_in = 1'b1;
      pxl_in   = DW'($urandom);
      repeat (3) begin @(posedge clk); #1; end
      valid_in = 1'b0;
    end
  endtask

  task automatic start_run(input int id, input bit random_px);
    for (int p = 0; p < TOTAL; p++) stream[p] = random_px ? DW'($urandom) : DW'(p);
    build_model();
    ev_cnt   = 0;
    run_id   = id;
    trig_cyc = -1;
    idle_cyc = -1;
    mon_en   = 1'b1;
  endtask

  task automatic finish_run();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    check("end_state_idle", EW'(state_o), EW'(0));
    check("end_valid_low", EW'(valid_out), EW'(0));
    check("event_count", EW'(ev_cnt), EW'(n_exp));
    mon_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_win"}, EW'(win_out), EW'(0));
    check({tag, "_valid"}, EW'(valid_out), EW'(0));
    check({tag, "_last"}, EW'(last_out), EW'(0));
    check({tag, "_state"}, EW'(state_o), EW'(0));
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = '0;
    repeat (3) @(posedge clk);
    check_reset_state("rst0");
    @(posedge clk); #1;
    reset = 1'b0;

    // run 1: index-valued pixels, continuous
    start_run(1, 1'b0);
    drive_stream(0, TOTAL);
    finish_run();

    // run 2: same stream with valid_in toggling
    start_run(2, 1'b0);
    drive_stream(1, TOTAL);
    finish_run();

    // run 3: abort after 10 pixels with reset, then a fresh layer
    for (int p = 0; p < TOTAL; p++) stream[p] = DW'(p);
    mon_en = 1'b0;
    drive_stream(0, 10);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_state("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    start_run(3, 1'b0);
    drive_stream(0, TOTAL);
    finish_run();

    // runs 4-5: random pixels, random gaps, junk valid_in during flush
    for (int r = 0; r < 2; r++) begin
      start_run(4 + r, 1'b1);
      drive_stream(2, TOTAL);
      finish_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
